// File: rtl/instr_register_sched.sv
// Write scheduler and in-order read sequencer for the 32-entry instruction register.
// Round-robin arbitration across NUM_REQ producers; the register is run as a circular buffer.
package instr_register_pkg;
  typedef enum logic [3:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;
  typedef logic signed [31:0] operand_t;
  typedef logic [4:0]         address_t;
  typedef logic signed [63:0] result_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
    result_t  res;
  } instruction_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t a;
    operand_t b;
  } req_t;
endpackage

// One arbitration lane: wins when valid and no valid lane sits strictly between rr_last and it.
module irs_rr_lane #(
  parameter int NUM_REQ = 2,
  parameter int IDX     = 0
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [1:0]         rr_last,
  output logic               win
);
  int d_self;
  int d_j;

  always_comb begin
    win    = req_valid[IDX];
    d_self = IDX - int'(rr_last) - 1;
    if (d_self < 0) d_self = d_self + NUM_REQ;
    d_j    = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      d_j = j - int'(rr_last) - 1;
      if (d_j < 0) d_j = d_j + NUM_REQ;
      if (req_valid[j] && (d_j < d_self)) win = 1'b0;
    end
  end
endmodule

module instr_register_sched
  import instr_register_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DEPTH   = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  opcode_t  [NUM_REQ-1:0]   req_opcode,
  input  operand_t [NUM_REQ-1:0]   req_op_a,
  input  operand_t [NUM_REQ-1:0]   req_op_b,
  input  logic                     flush,
  output logic                     load_en,
  output address_t                 write_pointer,
  output opcode_t                  opcode,
  output operand_t                 operand_a,
  output operand_t                 operand_b,
  output address_t                 read_pointer,
  input  instruction_t             instruction_word,
  output logic                     out_valid,
  input  logic                     out_ready,
  output instruction_t             out_word,
  output logic [1:0]               grant_id,
  output logic [5:0]               count
);
  localparam logic [5:0] DEPTH_C = 6'(DEPTH);

  address_t             wr_ptr, rd_ptr;
  logic [5:0]           alloc_cnt, commit_cnt;
  logic [1:0]           rr_last;
  logic [NUM_REQ-1:0]   win;
  logic [1:0]           gid;
  req_t                 sel;
  logic                 full, accept, pop;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    irs_rr_lane #(.NUM_REQ(NUM_REQ), .IDX(g)) u_lane (
      .req_valid (req_valid),
      .rr_last   (rr_last),
      .win       (win[g])
    );
  end

  // win is one-hot, so the last match is the only match
  always_comb begin
    gid = rr_last;
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win[i]) begin
        gid   = 2'(i);
        sel.opc = req_opcode[i];
        sel.a   = req_op_a[i];
        sel.b   = req_op_b[i];
      end
    end
  end

  assign full      = (alloc_cnt == DEPTH_C);
  // Ready only looks at registered occupancy, never at out_ready
  assign req_ready = win & {NUM_REQ{~full & ~flush & reset_n}};
  assign accept    = |(req_valid & req_ready);
  assign out_valid = (commit_cnt != 6'd0);
  assign pop       = out_valid & out_ready & ~flush;

  assign read_pointer = rd_ptr;
  assign out_word     = instruction_word;
  assign count        = alloc_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      alloc_cnt     <= '0;
      commit_cnt    <= '0;
      rr_last       <= 2'(NUM_REQ - 1);
      load_en       <= 1'b0;
      write_pointer <= '0;
      opcode        <= ZERO;
      operand_a     <= '0;
      operand_b     <= '0;
      grant_id      <= '0;
    end else if (flush) begin
      // An in-flight load still lands in the register but is deliberately not counted
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      alloc_cnt  <= '0;
      commit_cnt <= '0;
      rr_last    <= '0;
      load_en    <= 1'b0;
    end else begin
      load_en <= accept;
      if (accept) begin
        opcode        <= sel.opc;
        operand_a     <= sel.a;
        operand_b     <= sel.b;
        write_pointer <= wr_ptr;
        wr_ptr        <= wr_ptr + 5'd1;
        rr_last       <= gid;
        grant_id      <= gid;
      end
      if (pop) rd_ptr <= rd_ptr + 5'd1;
      alloc_cnt  <= alloc_cnt  + {5'd0, accept}  - {5'd0, pop};
      commit_cnt <= commit_cnt + {5'd0, load_en} - {5'd0, pop};
    end
  end
endmodule

// File: tb/tb_instr_register_sched.sv
// Directed bench for instr_register_sched with a behavioural instruction register attached.
module tb_instr_register_sched;
  import instr_register_pkg::*;

  localparam int NR = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]     req_valid, req_ready;
  opcode_t  [NR-1:0] req_opcode;
  operand_t [NR-1:0] req_op_a, req_op_b;
  logic              flush, load_en, out_valid, out_ready;
  address_t          write_pointer, read_pointer;
  opcode_t           opcode;
  operand_t          operand_a, operand_b;
  instruction_t      instruction_word, out_word;
  logic [1:0]        grant_id;
  logic [5:0]        count;

  instr_register_sched #(.NUM_REQ(NR), .DEPTH(32)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_opcode       (req_opcode),
    .req_op_a         (req_op_a),
    .req_op_b         (req_op_b),
    .flush            (flush),
    .load_en          (load_en),
    .write_pointer    (write_pointer),
    .opcode           (opcode),
    .operand_a        (operand_a),
    .operand_b        (operand_b),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_word         (out_word),
    .grant_id         (grant_id),
    .count            (count)
  );

  // Behavioural instruction register: computes the result when written, reads combinationally
  instruction_t regs [32];

  function automatic result_t calc(opcode_t o, operand_t a, operand_t b);
    case (o)
      PASSA:   return result_t'(a);
      PASSB:   return result_t'(b);
      ADD:     return result_t'(a) + result_t'(b);
      SUB:     return result_t'(a) - result_t'(b);
      MULT:    return result_t'(a) * result_t'(b);
      default: return '0;
    endcase
  endfunction

  always @(posedge clk)
    if (load_en)
      regs[write_pointer] <= '{opc: opcode, op_a: operand_a, op_b: operand_b,
                               res: calc(opcode, operand_a, operand_b)};

  assign instruction_word = regs[read_pointer];

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p, input opcode_t o, input int a, input int b);
    req_opcode[p] = o;
    req_op_a[p]   = a;
    req_op_b[p]   = b;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = '0;
    req_valid  = '0;
    req_opcode = {ZERO, ZERO};
    req_op_a   = '0;
    req_op_b   = '0;
    flush      = 1'b0;
    out_ready  = 1'b0;

    // Reset state
    #12;
    check("rst_load_en", 64'(load_en), 64'd0);
    check("rst_wp", 64'(write_pointer), 64'd0);
    check("rst_rp", 64'(read_pointer), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_grant", 64'(grant_id), 64'd0);
    check("rst_opcode", 64'(opcode), 64'(ZERO));
    @(negedge clk);
    reset_n = 1'b1;

    // Single write: ADD 5,3
    drive(1'b0, ADD, 5, 3);
    req_valid = 2'b01;
    #1;
    check("sw_req_ready", 64'(req_ready), 64'd1);
    tick();
    req_valid = '0;
    check("sw_load_en", 64'(load_en), 64'd1);
    check("sw_wp", 64'(write_pointer), 64'd0);
    check("sw_out_valid_e1", 64'(out_valid), 64'd0);
    check("sw_opcode", 64'(opcode), 64'(ADD));
    tick();
    check("sw_out_valid_e2", 64'(out_valid), 64'd1);
    check("sw_rp", 64'(read_pointer), 64'd0);
    check("sw_opc", 64'(out_word.opc), 64'(ADD));
    check("sw_res", out_word.res, 64'd8);
    check("sw_load_en_off", 64'(load_en), 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("sw_pop_valid", 64'(out_valid), 64'd0);
    check("sw_pop_count", 64'(count), 64'd0);
    check("sw_pop_rp", 64'(read_pointer), 64'd1);

    // Asynchronous reset in the middle of a cycle with a load pending
    drive(1'b1, PASSA, 9, 0);
    req_valid = 2'b10;
    tick();
    check("ar_pre_load_en", 64'(load_en), 64'd1);
    check("ar_pre_grant", 64'(grant_id), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_load_en", 64'(load_en), 64'd0);
    check("ar_wp", 64'(write_pointer), 64'd0);
    check("ar_rp", 64'(read_pointer), 64'd0);
    check("ar_count", 64'(count), 64'd0);
    check("ar_grant", 64'(grant_id), 64'd0);
    check("ar_req_ready", 64'(req_ready), 64'd0);
    check("ar_opcode", 64'(opcode), 64'(ZERO));
    req_valid = '0;
    @(negedge clk);
    reset_n = 1'b1;

    // Round-robin: both producers held valid, then producer 1 alone
    drive(1'b0, SUB, 10, 4);
    drive(1'b1, MULT, -3, 7);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_grant", 64'(grant_id), 64'(k % 2));
      check("rr_wp", 64'(write_pointer), 64'(k));
    end
    req_valid = 2'b10;
    for (int k = 4; k < 6; k++) begin
      tick();
      check("rr1_grant", 64'(grant_id), 64'd1);
      check("rr1_wp", 64'(write_pointer), 64'(k));
    end
    req_valid = '0;
    tick();
    check("rr_count", 64'(count), 64'd6);
    check("rr_head_opc", 64'(out_word.opc), 64'(SUB));
    check("rr_head_res", out_word.res, 64'd6);

    // Bring count to 5, then accept and pop on the same edge
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("cp_pre_count", 64'(count), 64'd5);
    check("cp_pre_res", out_word.res, 64'hFFFF_FFFF_FFFF_FFEB);
    drive(1'b0, ADD, 1, 1);
    req_valid = 2'b01;
    out_ready = 1'b1;
    tick();
    req_valid = '0;
    out_ready = 1'b0;
    check("cp_count", 64'(count), 64'd5);
    check("cp_rp", 64'(read_pointer), 64'd2);
    check("cp_wp", 64'(write_pointer), 64'd6);

    // Flush at count 7 with a request pending and a load in flight
    req_valid = 2'b01;
    tick();
    tick();
    flush = 1'b1;
    #1;
    check("fl_pre_count", 64'(count), 64'd7);
    check("fl_req_ready", 64'(req_ready), 64'd0);
    tick();
    flush = 1'b0;
    req_valid = '0;
    check("fl_count", 64'(count), 64'd0);
    check("fl_out_valid", 64'(out_valid), 64'd0);
    check("fl_load_en", 64'(load_en), 64'd0);
    tick();
    check("fl_inflight_uncounted", 64'(out_valid), 64'd0);
    drive(1'b1, PASSB, 1, 42);
    req_valid = 2'b10;
    tick();
    req_valid = '0;
    check("fl_next_wp", 64'(write_pointer), 64'd0);
    tick();
    check("fl_next_valid", 64'(out_valid), 64'd1);
    check("fl_next_rp", 64'(read_pointer), 64'd0);
    check("fl_next_res", out_word.res, 64'd42);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("fl_drain_count", 64'(count), 64'd0);

    // Full and wrap from a clean queue
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, ADD, 0, 100);
    req_valid = 2'b01;
    for (int i = 0; i < 32; i++) begin
      tick();
      check("fill_wp", 64'(write_pointer), 64'(i));
      req_op_a[0] = i + 1;
    end
    check("full_count", 64'(count), 64'd32);
    check("full_req_ready", 64'(req_ready), 64'd0);
    check("full_head_res", out_word.res, 64'd100);
    tick();
    check("full_hold_count", 64'(count), 64'd32);
    check("full_hold_load_en", 64'(load_en), 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("wrap_pop_count", 64'(count), 64'd31);
    check("wrap_pop_rp", 64'(read_pointer), 64'd1);
    check("wrap_req_ready", 64'(req_ready), 64'd1);
    check("wrap_head_a", 64'(out_word.op_a), 64'd1);
    tick();
    req_valid = '0;
    check("wrap_wp", 64'(write_pointer), 64'd0);
    check("wrap_load_en", 64'(load_en), 64'd1);
    check("wrap_count", 64'(count), 64'd32);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/instr_register_sched.md
# instr_register_sched

Multi-requester write scheduler and in-order read sequencer for the 32-entry instruction register. Arbitrates round-robin among NUM_REQ producers, accepts `{opcode, operand_a, operand_b}` over valid/ready, and drives the register's `load_en` and `write_pointer`. It also drives `read_pointer` so that the register behaves as a circular buffer. Results (`instruction_word`) are handed to one consumer in write order over valid/ready.

## Interface
- `NUM_REQ`, default 2: number of producers, legal range 2..4.
- `DEPTH`, default 32: register entries; must equal 2**width of `address_t` (5 bits).
- `clk`  in  1  Single clock; all state updates on the rising edge.
- `reset_n`  in  1  Asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  Per-producer request valid.
- `req_ready`  out  NUM_REQ  Per-producer accept; one-hot or zero.
- `req_opcode`  in  NUM_REQ x 4 (`opcode_t`)  Per-producer opcode.
- `req_op_a`, `req_op_b`  in  NUM_REQ x 32 (`operand_t`, signed)  Per-producer operands.
- `flush`  in  1  Synchronous clear of all queue state.
- `load_en`  out  1  Register write enable.
- `write_pointer`  out  5  Register write address.
- `opcode`  out  4  Register opcode input.
- `operand_a`, `operand_b`  out  32  Register operand inputs.
- `read_pointer`  out  5  Register read address.
- `instruction_word`  in  `instruction_t`  Register read data (combinational from `read_pointer`).
- `out_valid`  out  1  Head entry is committed and readable.
- `out_ready`  in  1  Consumer pops the head entry.
- `out_word`  out  `instruction_t`  Equals `instruction_word`.
- `grant_id`  out  2  Index of the last accepted producer.
- `count`  out  6  Allocated entries, 0..32.

## Operation
- **State:**
  - `wr_ptr`, `rd_ptr`: 5 bits each, wrap modulo 32.
  - `alloc_cnt`: 6 bits; entries accepted and not yet popped.
  - `commit_cnt`: 6 bits; entries written to the register and not yet popped.
  - `rr_last`: last granted producer.
- **Arbitration:** each cycle the winner is the first asserted `req_valid` searching from `rr_last+1` upward, wrapping.
  - `req_ready[winner]=1` only when `alloc_cnt<DEPTH` and `flush=0`.
  - `req_ready` depends on registered state and `req_valid` only; it has no combinational path from `out_ready`.
- **Accept** (`req_valid[g] & req_ready[g]`) at edge E:
  - `opcode`/`operand_a`/`operand_b` ← producer g's data; `write_pointer` ← `wr_ptr`; `load_en` ← 1.
  - `wr_ptr++`, `alloc_cnt++`, `rr_last` ← g, `grant_id` ← g.
- **No accept** at edge E: `load_en` ← 0. Data, pointer and `grant_id` outputs hold their values.
- **Commit:** on any edge where `load_en=1`, `commit_cnt++`, because the register captures the entry at that edge.
- **Read side:**
  - `read_pointer` = `rd_ptr` (registered).
  - `out_valid` = (`commit_cnt>0`).
  - `out_word` = `instruction_word`.
- **Pop** (`out_valid & out_ready`): `rd_ptr++`, `alloc_cnt--`, `commit_cnt--`.
- **Simultaneous events:**
  - Accept and pop on the same edge: `alloc_cnt` is unchanged.
  - Commit and pop on the same edge: `commit_cnt` is unchanged.
- **Flush** (synchronous, highest priority):
  - Pointers, both counters and `rr_last` clear to 0; `load_en` ← 0.
  - Any accept or pop in that cycle is ignored, and `req_ready` is 0.
  - An in-flight write (`load_en=1` during the flush cycle) still reaches the register, but it is not counted.
- **Results:** arithmetic is performed by the register itself; this block never modifies data.

## Timing
- **Reset values:**
  - `load_en`=0, `write_pointer`=0, `read_pointer`=0.
  - `opcode`=ZERO, `operand_a`=`operand_b`=0.
  - `req_ready`=0, `out_valid`=0, `grant_id`=0, `count`=0, `rr_last`=NUM_REQ-1 (so producer 0 has first priority).
- **Reset mid-operation:**
  - Asserting `reset_n` clears all state immediately, whatever the clock phase.
  - Deassertion takes effect at the next rising edge.
  - Any pending `load_en` is dropped.
- **Latency:**
  - Accept at edge E → `load_en`=1 during cycle E..E+1 → register written at E+1.
  - `out_valid`=1 from E+1, when the queue was empty.
  - Accept-to-readable latency is therefore 2 edges.
- **Throughput:** one accept per cycle and one pop per cycle, concurrently.
- **Full** (`alloc_cnt`=32): all `req_ready`=0. A pop at edge P makes `req_ready` available from P onward, with no combinational bypass.
- **Empty:** `out_valid`=0. `out_ready` is ignored.
- **Wrap:** entry 33 is written to address 0 once address 0 has been popped.
- **Producer protocol:** producers must hold `req_valid` and data stable until accepted.

## Test plan
- **Reset:**
  - Stimulus: assert `reset_n`=0 asynchronously mid-cycle while `load_en`=1.
  - Response: all outputs immediately take their listed reset values; `count`=0.
- **Single write:**
  - Stimulus: producer 0 sends ADD, a=5, b=3, accepted at edge 1.
  - Response: `load_en`=1 with `write_pointer`=0 after edge 1; `out_valid`=1 after edge 2 with `read_pointer`=0 and `out_word.opc`=ADD, `res`=8.
  - Follow-up: pop → `out_valid`=0.
- **Round-robin:**
  - Stimulus: producers 0 and 1 hold `req_valid` continuously for 4 accepts.
  - Response: `grant_id` sequence 0,1,0,1 with `write_pointer` 0,1,2,3.
  - Follow-up: with only producer 1 valid, it is granted every cycle.
- **Full and wrap:**
  - Stimulus: perform 32 accepts with `out_ready`=0.
  - Response: `count`=32 and `req_ready`=0.
  - Follow-up: one pop → the next accept writes `write_pointer`=0, and `count` returns to 32.
- **Concurrent push/pop:**
  - Stimulus: at `count`=5, accept and pop on the same edge.
  - Response: `count` stays 5; `read_pointer` advances by 1; `write_pointer` advances by 1.
- **Flush:**
  - Stimulus: assert `flush` with `count`=7 and `req_valid` high.
  - Response: `req_ready`=0 in that cycle; next cycle `count`=0, `out_valid`=0, and `read_pointer`/`write_pointer` return to 0 on the next accept.
